wb_master_seq: RTL

Wishbone classic single-transfer initiator for the user project area. It takes one read or write command at a time from a valid/ready command port and drives it onto the Wishbone bus toward user-area responders, such as the 0x380xxxxx BRAM/counter slave. It returns read data, an error flag and the measured ack latency on a valid/ready response port. A cycle counter aborts any transfer whose responder never acks.

---
 rtl/wb_master_seq.sv | 72 +++++++
 1 files changed

// File: rtl/wb_master_seq.sv
// wb_master_seq: Wishbone classic single-transfer initiator with ack-latency measurement and timeout abort
module wb_master_seq #(
  parameter int TIMEOUT = 64,
  parameter int LAT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_we,
  input  logic [3:0]       cmd_sel,
  input  logic [31:0]      cmd_adr,
  input  logic [31:0]      cmd_dat,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [31:0]      rsp_dat,
  output logic             rsp_err,
  output logic [LAT_W-1:0] rsp_lat,
  output logic             wbm_cyc_o,
  output logic             wbm_stb_o,
  output logic             wbm_we_o,
  output logic [3:0]       wbm_sel_o,
  output logic [31:0]      wbm_adr_o,
  output logic [31:0]      wbm_dat_o,
  input  logic             wbm_ack_i,
  input  logic [31:0]      wbm_dat_i
);
  typedef enum logic [1:0] {IDLE, BUS, RESP} state_t;
  localparam logic [LAT_W-1:0] CNT_LAST = LAT_W'(TIMEOUT - 1);
  state_t state, state_n;
  logic [LAT_W-1:0] cnt;
  logic ack_hit, to_hit;
  assign cmd_ready = state == IDLE;
  // next state; ack takes priority over timeout in the same cycle
  always_comb begin
    ack_hit = state == BUS && wbm_ack_i;
    to_hit = state == BUS && !wbm_ack_i && cnt == CNT_LAST;
    state_n = state;
    state_n = (state == IDLE && cmd_valid) ? BUS :
              (ack_hit || to_hit) ? RESP :
              (state == RESP && rsp_ready) ? IDLE : state;
  end
  // state register
  always_ff @(posedge clk)
    if (rst) state <= IDLE;
    else state <= state_n;
  // bus and response registers
  always_ff @(posedge clk) begin
    if (rst) begin
      {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} <= '0;
      {rsp_valid, rsp_err, rsp_lat, rsp_dat} <= '0;
      cnt <= '0;
    end else begin
      if (state == IDLE && cmd_valid) begin
        {wbm_cyc_o, wbm_stb_o} <= 2'b11;
        {wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} <= {cmd_we, cmd_sel, cmd_adr, cmd_dat};
        cnt <= '0;
      end
      if (state == BUS) begin
        cnt <= (&cnt) ? cnt : cnt + 1'b1;
        if (ack_hit || to_hit) begin
          {wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o} <= '0;
          rsp_valid <= 1'b1;
          rsp_err <= to_hit;
          rsp_dat <= (ack_hit && !wbm_we_o) ? wbm_dat_i : 32'd0;
          rsp_lat <= ack_hit ? cnt + 1'b1 : LAT_W'(TIMEOUT);
        end
      end
      if (state == RESP && rsp_ready) rsp_valid <= 1'b0;
    end
  end
endmodule
